// File: rtl/multicycle_control.sv
// Multicycle processor control unit: Moore FSM sequencing fetch, decode,
// memory access, execute and write-back, plus a registered illegal-opcode pulse.
//
// state     | code | meaning
// FETCH     |  0   | read instruction, PC+4 (commits when mem_ready)
// DECODE    |  1   | read registers, compute branch target
// MEM_ADDR  |  2   | compute lw/sw effective address
// MEM_READ  |  3   | data read, waits for mem_ready
// MEM_WB    |  4   | write loaded data to rt
// MEM_WRITE |  5   | data write, waits for mem_ready
// EXEC_R    |  6   | R-type ALU operation
// R_WB      |  7   | write ALU result to rd
// BRANCH    |  8   | beq compare and conditional PC update
// JUMP      |  9   | PC <- jump target
// ADDI_EXEC | 10   | rs + sign-extended immediate
// ADDI_WB   | 11   | write ALU result to rt
module multicycle_control (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  input  logic       zero,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_source,
  output logic [1:0] alu_op,
  output logic [3:0] state,
  output logic       illegal_op
);

  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    MEM_ADDR  = 4'd2,
    MEM_READ  = 4'd3,
    MEM_WB    = 4'd4,
    MEM_WRITE = 4'd5,
    EXEC_R    = 4'd6,
    R_WB      = 4'd7,
    BRANCH    = 4'd8,
    JUMP      = 4'd9,
    ADDI_EXEC = 4'd10,
    ADDI_WB   = 4'd11
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  state_t state_q, state_d;
  logic   illegal_d;

  // zero is accepted for interface completeness; beq resolves in the datapath
  // through pc_write_cond, so the FSM never needs to look at it.
  logic   unused_zero;
  assign unused_zero = zero;

  assign state = state_q;

  // State and illegal-opcode registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= FETCH;
      illegal_op <= 1'b0;
    end else begin
      state_q    <= state_d;
      illegal_op <= illegal_d;
    end
  end

  // Next-state and Moore output decode; everything defaults to 0 / FETCH.
  always_comb begin
    state_d       = FETCH;
    illegal_d     = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    pc_source     = 2'b00;
    alu_op        = 2'b00;
    case (state_q)
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        state_d   = mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        alu_src_b = 2'b11;
        case (opcode)
          OP_LW, OP_SW: state_d = MEM_ADDR;
          OP_R:         state_d = EXEC_R;
          OP_BEQ:       state_d = BRANCH;
          OP_J:         state_d = JUMP;
          OP_ADDI:      state_d = ADDI_EXEC;
          default: begin
            state_d   = FETCH;
            illegal_d = 1'b1;
          end
        endcase
      end
      MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = (opcode == OP_SW) ? MEM_WRITE : MEM_READ;
      end
      MEM_READ: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        state_d  = mem_ready ? MEM_WB : MEM_READ;
      end
      MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      MEM_WRITE: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        state_d   = mem_ready ? FETCH : MEM_WRITE;
      end
      EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        state_d   = R_WB;
      end
      R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
      end
      JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
      end
      ADDI_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = ADDI_WB;
      end
      ADDI_WB: begin
        reg_write = 1'b1;
      end
      default: state_d = FETCH;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: each instruction is expanded into its expected
// per-cycle state trace from the opcode class and stall counts, then driven and
// compared cycle by cycle, including output decode and illegal_op.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       zero;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a;
  logic [1:0] alu_src_b, pc_source, alu_op;
  logic [3:0] state;
  logic       illegal_op;

  int tests  = 0;
  int failed = 0;
  bit pending_illegal = 1'b0;

  multicycle_control dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready), .zero(zero),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_source(pc_source),
    .alu_op(alu_op), .state(state), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100, OP_ADDI = 6'b001000, OP_J = 6'b000010;

  function automatic logic [15:0] observed();
    return {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
            mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, pc_source, alu_op};
  endfunction

  // Output table written straight from the per-state control listing.
  function automatic logic [15:0] expect_out(input int st, input logic mr);
    logic pw = 0, pwc = 0, iod = 0, mrd = 0, mwr = 0, irw = 0, m2r = 0, rdst = 0, rw = 0, sa = 0;
    logic [1:0] sb = 0, ps = 0, ao = 0;
    case (st)
      0:  begin mrd = 1; sb = 2'b01; irw = mr; pw = mr; end
      1:  sb = 2'b11;
      2:  begin sa = 1; sb = 2'b10; end
      3:  begin mrd = 1; iod = 1; end
      4:  begin rw = 1; m2r = 1; end
      5:  begin mwr = 1; iod = 1; end
      6:  begin sa = 1; ao = 2'b10; end
      7:  begin rw = 1; rdst = 1; end
      8:  begin sa = 1; ao = 2'b01; pwc = 1; ps = 2'b01; end
      9:  begin pw = 1; ps = 2'b10; end
      10: begin sa = 1; sb = 2'b10; end
      11: rw = 1;
      default: ;
    endcase
    return {pw, pwc, iod, mrd, mwr, irw, m2r, rdst, rw, sa, sb, ps, ao};
  endfunction

  // Runs one instruction: expected trace built from opcode class and stalls.
  task automatic run_instr(input string name, input logic [5:0] op, input int fstall,
                           input int mstall, input logic z);
    int  st_q[$];
    bit  mr_q[$];
    bit  illegal;
    illegal = 0;
    for (int i = 0; i < fstall; i++) begin st_q.push_back(0); mr_q.push_back(0); end
    st_q.push_back(0); mr_q.push_back(1);
    st_q.push_back(1); mr_q.push_back(1'($urandom));
    case (op)
      OP_R:    begin st_q.push_back(6); st_q.push_back(7); end
      OP_ADDI: begin st_q.push_back(10); st_q.push_back(11); end
      OP_BEQ:  st_q.push_back(8);
      OP_J:    st_q.push_back(9);
      OP_LW: begin
        st_q.push_back(2);
        for (int i = 0; i <= mstall; i++) st_q.push_back(3);
        st_q.push_back(4);
      end
      OP_SW: begin
        st_q.push_back(2);
        for (int i = 0; i <= mstall; i++) st_q.push_back(5);
      end
      default: illegal = 1;
    endcase
    // Memory-wait states see mem_ready low for mstall cycles then high;
    // other post-decode cycles get random mem_ready, which must not matter.
    while (mr_q.size() < st_q.size()) begin
      int idx = mr_q.size();
      if (st_q[idx] == 3 || st_q[idx] == 5)
        mr_q.push_back((idx + 1 < st_q.size() && st_q[idx + 1] == st_q[idx]) ? 1'b0 : 1'b1);
      else
        mr_q.push_back(1'($urandom));
    end
    opcode = op;
    zero   = z;
    for (int i = 0; i < st_q.size(); i++) begin
      logic [15:0] want;
      mem_ready = mr_q[i];
      @(negedge clk);
      want = expect_out(st_q[i], mr_q[i]);
      tests++;
      if (state !== 4'(st_q[i])) begin
        failed++;
        $display("FAIL %s state cyc%0d: got %0d want %0d", name, i, state, st_q[i]);
      end
      tests++;
      if (observed() !== want) begin
        failed++;
        $display("FAIL %s outputs cyc%0d st%0d: got %h want %h", name, i, st_q[i], observed(), want);
      end
      tests++;
      if (illegal_op !== ((i == 0) && pending_illegal)) begin
        failed++;
        $display("FAIL %s illegal_op cyc%0d: got %b want %b", name, i, illegal_op,
                 (i == 0) && pending_illegal);
      end
      @(posedge clk);
      #1;
    end
    pending_illegal = illegal;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    mem_ready = 1'b0;
    #2;
    tests++;
    if (state !== 4'd0 || illegal_op !== 1'b0) begin
      failed++;
      $display("FAIL reset_state: got state %0d illegal %b want 0 0", state, illegal_op);
    end
    tests++;
    if (observed() !== expect_out(0, 1'b0)) begin
      failed++;
      $display("FAIL reset_out_mr0: got %h want %h", observed(), expect_out(0, 1'b0));
    end
    mem_ready = 1'b1;
    #1;
    tests++;
    if (observed() !== expect_out(0, 1'b1)) begin
      failed++;
      $display("FAIL reset_out_mr1: got %h want %h", observed(), expect_out(0, 1'b1));
    end
    @(posedge clk);
    #1;
    tests++;
    if (state !== 4'd0) begin
      failed++;
      $display("FAIL reset_hold: got %0d want 0", state);
    end
    mem_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    pending_illegal = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
  endtask

  task automatic test_directed();
    run_instr("rtype", OP_R, 0, 0, 1'b0);
    run_instr("lw_stall2", OP_LW, 0, 2, 1'b0);
    run_instr("fetch_stall3", OP_ADDI, 3, 0, 1'b0);
    run_instr("beq_z1", OP_BEQ, 0, 0, 1'b1);
    run_instr("beq_z0", OP_BEQ, 0, 0, 1'b0);
    run_instr("jump", OP_J, 1, 0, 1'b1);
    run_instr("sw_stall1", OP_SW, 0, 1, 1'b0);
    run_instr("illegal_3f", 6'b111111, 0, 0, 1'b0);
    run_instr("after_illegal", OP_R, 2, 0, 1'b0);
  endtask

  // Reset asserted while waiting in a memory state must act immediately.
  task automatic test_reset_mid_mem(input logic [5:0] op, input int mem_st);
    opcode = op;
    mem_ready = 1'b1;
    repeat (3) @(posedge clk);
    mem_ready = 1'b0;
    @(negedge clk);
    tests++;
    if (state !== 4'(mem_st)) begin
      failed++;
      $display("FAIL pre_reset_mem: got %0d want %0d", state, mem_st);
    end
    #1;
    rst_n = 1'b0;
    #1;
    tests++;
    if (state !== 4'd0 || mem_write !== 1'b0 || illegal_op !== 1'b0 || i_or_d !== 1'b0) begin
      failed++;
      $display("FAIL reset_mid_mem: got state %0d mem_write %b illegal %b i_or_d %b want 0 0 0 0",
               state, mem_write, illegal_op, i_or_d);
    end
    do_reset();
  endtask

  task automatic test_reset_clears_illegal();
    run_instr("illegal_pre_reset", 6'b010101, 0, 0, 1'b0);
    tests++;
    if (illegal_op !== 1'b1) begin
      failed++;
      $display("FAIL illegal_before_reset: got %b want 1", illegal_op);
    end
    rst_n = 1'b0;
    #1;
    tests++;
    if (illegal_op !== 1'b0) begin
      failed++;
      $display("FAIL illegal_async_clear: got %b want 0", illegal_op);
    end
    do_reset();
  endtask

  task automatic test_back_to_back();
    logic [5:0] legal [6] = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J};
    for (int n = 0; n < 60; n++) begin
      logic [5:0] op;
      int pick = $urandom_range(0, 6);
      if (pick < 6) op = legal[pick];
      else begin
        op = 6'($urandom);
        while (op == OP_R || op == OP_LW || op == OP_SW || op == OP_BEQ ||
               op == OP_ADDI || op == OP_J) op = 6'($urandom);
      end
      run_instr("random", op, $urandom_range(0, 2), $urandom_range(0, 3), 1'($urandom));
    end
  endtask

  initial begin
    opcode = 6'd0;
    zero = 1'b0;
    mem_ready = 1'b0;
    rst_n = 1'b0;
    #3;
    test_reset();
    test_directed();
    test_reset_mid_mem(OP_SW, 5);
    test_reset_mid_mem(OP_LW, 3);
    test_reset_clears_illegal();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have no parameters; all encodings are fixed by this spec.
REQ-002 SHALL provide: clk  input  1  rising-edge clock.
REQ-003 SHALL provide: rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL provide: opcode  input  6  instruction[31:26], valid from the cycle after ir_write.
REQ-005 SHALL provide: mem_ready  input  1  memory completed the access this cycle.
REQ-006 SHALL provide: zero  input  1  ALU zero flag (sampled only in BRANCH).
REQ-007 SHALL provide: pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a  output  1 each  datapath strobes/selects.
REQ-008 SHALL provide: alu_src_b  output  2  00 regB, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2.
REQ-009 SHALL provide: pc_source  output  2  00 ALU result, 01 ALUOut, 10 jump target.
REQ-010 SHALL provide: alu_op  output  2  00 add, 01 sub, 10 R-type (funct-decoded by ALU control); 11 never driven.
REQ-011 SHALL provide: state  output  4  current state code (debug).
REQ-012 SHALL provide: illegal_op  output  1  one-cycle pulse on unsupported opcode.

Function
REQ-013 SHALL implement a Moore FSM: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, EXEC_R=6, R_WB=7, BRANCH=8, JUMP=9, ADDI_EXEC=10, ADDI_WB=11; codes 12-15 unreachable and SHALL go to FETCH.
REQ-014 Supported opcodes SHALL be: R 000000, lw 100011, sw 101011, beq 000100, addi 001000, j 000010.
REQ-015 FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00, ir_write=pc_write=mem_ready; stay in FETCH while mem_ready=0, else go to DECODE.
REQ-016 DECODE: alu_src_a=0, alu_src_b=11, alu_op=00; next state by opcode: lw/sw->MEM_ADDR, R->EXEC_R, beq->BRANCH, j->JUMP, addi->ADDI_EXEC, other->FETCH.
REQ-017 MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00; lw->MEM_READ, sw->MEM_WRITE.
REQ-018 MEM_READ: mem_read=1, i_or_d=1; hold until mem_ready=1, then MEM_WB.
REQ-019 MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0; ->FETCH.
REQ-020 MEM_WRITE: mem_write=1, i_or_d=1; hold until mem_ready=1, then FETCH.
REQ-021 EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=10; ->R_WB. R_WB: reg_write=1, reg_dst=1, mem_to_reg=0; ->FETCH.
REQ-022 BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01; ->FETCH regardless of zero.
REQ-023 JUMP: pc_write=1, pc_source=10; ->FETCH.
REQ-024 ADDI_EXEC: alu_src_a=1, alu_src_b=10, alu_op=00; ->ADDI_WB. ADDI_WB: reg_write=1, reg_dst=0, mem_to_reg=0; ->FETCH.
REQ-025 Any output not listed for a state SHALL be 0 in that state.
REQ-026 Outputs other than illegal_op SHALL be combinational from state (plus mem_ready in FETCH); no output SHALL depend on opcode directly.
REQ-027 illegal_op SHALL be a register set for exactly one cycle after a DECODE cycle with an unsupported opcode.
REQ-028 Instruction latency: R/addi 4 cycles, lw 5, sw 4, beq 3, j 3, illegal 2 (each memory state +1 per mem_ready=0 cycle).

Reset
REQ-029 rst_n=0 SHALL immediately force state=FETCH and illegal_op=0, independent of clk, from any state including a stalled MEM_READ/MEM_WRITE.
REQ-030 During reset, outputs SHALL equal FETCH decode (mem_read=1, alu_src_b=01, all write strobes 0 unless mem_ready=1); first fetch begins on the first clk edge after rst_n rises.

Verification
REQ-031 R-type, mem_ready=1: state 0,1,6,7,0; reg_write=1 and reg_dst=1 only in state 7; alu_op=10 in state 6.
REQ-032 lw, mem_ready low 2 cycles in MEM_READ: state 0,1,2,3,3,3,4,0; mem_to_reg=1 in state 4.
REQ-033 FETCH with mem_ready=0 for 3 cycles: state holds 0, ir_write=pc_write=0; both 1 in the cycle mem_ready=1.
REQ-034 beq with zero=1 then zero=0: state 0,1,8,0; pc_write_cond=1, alu_op=01, pc_source=01 in state 8.
REQ-035 opcode 111111: state 0,1,0; illegal_op=1 for exactly the cycle following DECODE.
REQ-036 rst_n asserted mid-MEM_WRITE: state=0 and mem_write=0 before the next clk edge; illegal_op=0.
